// File: rtl/crc_result_monitor.sv
// Checks a CRC generator's result stream against packet ends and folds each result into a rotating signature.
// All outputs are registered, with one cycle of latency. There is no backpressure: results arriving too late or with nothing outstanding are flagged as errors.
module crc_result_monitor #(
  parameter int                   CRC_WIDTH   = 32,
  parameter logic [7:0]           PKT_LIMIT   = 8'd100,
  parameter int                   MAX_LAT     = 16,
  parameter int                   OUTST_WIDTH = 4,
  parameter logic [CRC_WIDTH-1:0] EXP_SIG     = {CRC_WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pkt_end,
  input  logic [CRC_WIDTH-1:0] crc_in,
  input  logic                 crc_vld,
  output logic [CRC_WIDTH-1:0] signature,
  output logic [7:0]           res_cnt,
  output logic                 done,
  output logic                 pass,
  output logic                 err_lat,
  output logic                 err_unexp,
  output logic                 err_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [OUTST_WIDTH-1:0] OUTST_MAX = '1;
  localparam logic [7:0]             LAT_LIMIT = 8'(MAX_LAT);

  state_t                 state_q, state_d;
  logic [7:0]             sent_cnt_q, sent_cnt_d;
  logic [OUTST_WIDTH-1:0] outst_q, outst_d;
  logic [7:0]             lat_tmr_q, lat_tmr_d;
  logic [CRC_WIDTH-1:0]   signature_q, signature_d;
  logic [7:0]             res_cnt_q, res_cnt_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic                   err_lat_q, err_lat_d;
  logic                   err_unexp_q, err_unexp_d;
  logic                   err_ovf_q, err_ovf_d;

  logic active, outst_nz, lat_tmo, accept, unexp, count, ovf;

  assign active   = (state_q == RUN) || (state_q == DRAIN);
  assign outst_nz = (outst_q != '0);
  // A result arriving on the same edge as the timeout is late, so it is rejected.
  assign lat_tmo  = active && outst_nz && (lat_tmr_q >= LAT_LIMIT);
  assign accept   = active && crc_vld && outst_nz && !lat_tmo;
  assign unexp    = active && crc_vld && !outst_nz;
  assign count    = (state_q == RUN) && pkt_end;
  assign ovf      = count && (outst_q == OUTST_MAX) && !accept;

  always_comb begin
    state_d     = state_q;
    sent_cnt_d  = sent_cnt_q;
    outst_d     = outst_q;
    lat_tmr_d   = lat_tmr_q;
    signature_d = signature_q;
    res_cnt_d   = res_cnt_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_lat_d   = err_lat_q;
    err_unexp_d = err_unexp_q;
    err_ovf_d   = err_ovf_q;

    if (!start) begin
      state_d     = IDLE;
      sent_cnt_d  = '0;
      outst_d     = '0;
      lat_tmr_d   = '0;
      signature_d = '0;
      res_cnt_d   = '0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      err_lat_d   = 1'b0;
      err_unexp_d = 1'b0;
      err_ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN, DRAIN: begin
          if (accept) begin
            signature_d = {signature_q[CRC_WIDTH-2:0], signature_q[CRC_WIDTH-1]} ^ crc_in;
            res_cnt_d   = res_cnt_q + 8'd1;
          end
          if (count) sent_cnt_d = sent_cnt_q + 8'd1;
          if (count && !accept && !ovf) outst_d = outst_q + 1'b1;
          else if (accept && !count)    outst_d = outst_q - 1'b1;
          lat_tmr_d   = (accept || !outst_nz) ? 8'd0 : lat_tmr_q + 8'd1;
          err_lat_d   = err_lat_q   | lat_tmo;
          err_unexp_d = err_unexp_q | unexp;
          err_ovf_d   = err_ovf_q   | ovf;
          if (lat_tmo || unexp || ovf) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = 1'b0;
          end else if (res_cnt_d == PKT_LIMIT) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (signature_d == EXP_SIG) && !(err_lat_q || err_unexp_q || err_ovf_q);
          end else if ((state_q == RUN) && (sent_cnt_d == PKT_LIMIT)) begin
            state_d = DRAIN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sent_cnt_q  <= '0;
      outst_q     <= '0;
      lat_tmr_q   <= '0;
      signature_q <= '0;
      res_cnt_q   <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_lat_q   <= 1'b0;
      err_unexp_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sent_cnt_q  <= sent_cnt_d;
      outst_q     <= outst_d;
      lat_tmr_q   <= lat_tmr_d;
      signature_q <= signature_d;
      res_cnt_q   <= res_cnt_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_lat_q   <= err_lat_d;
      err_unexp_q <= err_unexp_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign signature = signature_q;
  assign res_cnt   = res_cnt_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_lat   = err_lat_q;
  assign err_unexp = err_unexp_q;
  assign err_ovf   = err_ovf_q;

endmodule
